oflow_mem_buffer_arbiter: RTL
=============================

# oflow_mem_buffer_arbiter

Arbitrates a single MEM buffer wrapper between one write requester (core FSM, PE write path) and NUM_REQ read requesters (similarity-metric lanes). Sequences each transaction with the wrapper's start/ready/done handshakes, drives `rnw_st`, and gates per-lane beat strobes onto the shared wrapper controls. Sits between the core FSM / similarity-metric lanes and the MEM buffer wrapper.

## Interface
- NUM_REQ, 4, number of read requesters (2..8)
- TIMEOUT_WIDTH, 8, watchdog counter width (used only with watchdog compiled in)

- clk  in  1  clock
- reset_N  in  1  synchronous, active-high reset (name kept per codebase; polarity fixed: 1 = reset)
- wr_req  in  1  write transaction request (level)
- wr_beat_valid  in  1  write data valid this cycle
- wr_grant  out  1  write owns buffer
- rd_req  in  NUM_REQ  per-lane read request (level)
- rd_line_req  in  NUM_REQ  per-lane "ready for new line" strobe
- rd_grant  out  NUM_REQ  one-hot read owner
- done_read  in  1  from wrapper
- done_write  in  1  from wrapper
- start_read  out  1  one-cycle pulse to wrapper
- start_write  out  1  one-cycle pulse to wrapper
- rnw_st  out  1  1 = read, 0 = write
- read_new_line  out  1  gated rd_line_req of owner
- ready_from_core  out  1  gated wr_beat_valid
- busy  out  1  any grant active
- timeout_err  out  1  sticky watchdog flag

## Operation
- States: IDLE, WR_START, WR_ACTIVE, RD_START, RD_ACTIVE, RELEASE.
- IDLE: wr_req=1 -> WR_START, wr_grant set (write has strict priority). Else any rd_req -> RD_START, rd_grant = first set bit searching upward from rr_ptr, wrapping mod NUM_REQ. Else stay.
- WR_START: start_write=1, rnw_st=0 -> WR_ACTIVE.
- WR_ACTIVE: rnw_st=0; ready_from_core = wr_beat_valid; done_write=1 -> RELEASE.
- RD_START: start_read=1, rnw_st=1 -> RD_ACTIVE.
- RD_ACTIVE: read_new_line = |(rd_line_req & rd_grant); done_read=1 -> RELEASE.
- RELEASE: all grants cleared; after a read grant to lane i, rr_ptr <= (i+1) mod NUM_REQ; write grant leaves rr_ptr unchanged -> IDLE.
- Requests sampled only in IDLE; dropping req while granted is ignored, grant held until done.
- done_read/done_write ignored outside their ACTIVE state. Non-owner rd_line_req never reaches read_new_line.
- ready_from_core = 0 outside WR_ACTIVE; read_new_line = 0 outside RD_ACTIVE.
- busy = |rd_grant | wr_grant.

## Timing
- Reset values: rnw_st=1; start_read, start_write, wr_grant, rd_grant, busy, timeout_err = 0; rr_ptr=0; state IDLE.
- Reset mid-transaction: next edge returns to reset values; no start/done pulse completes.
- Registered: state, grants, rr_ptr, start_*, rnw_st. Combinational (state-gated): ready_from_core, read_new_line.
- Request seen in IDLE at edge t -> grant and START at t+1 -> ACTIVE at t+2.
- done at edge t -> RELEASE t+1 -> IDLE t+2 -> next START t+3 at earliest.
- start_* pulses exactly one cycle per transaction.
- rnw_st changes only on START entry/RELEASE exit, never during ACTIVE.
- rd_grant one-hot or zero at all times; never concurrent with wr_grant.

## Configuration
- OFLOW_MEM_ARB_WATCHDOG_EN defined: TIMEOUT_WIDTH-bit counter clears on START, increments each ACTIVE cycle without done; at all-ones, timeout_err <= 1 (sticky until reset) and FSM forces RELEASE (rr_ptr updated normally).
- Undefined: no counter; timeout_err tied 0; ACTIVE waits indefinitely for done.

## Test plan
- Reset then idle 10 cycles -> rnw_st=1, all other outputs 0.
- wr_req and rd_req=4'b0010 same cycle -> wr_grant first, start_write 1 cycle later, rnw_st=0; after done_write, RELEASE, IDLE, rd_grant=4'b0010 with start_read 3 cycles after done.
- rd_req=4'b1111 held, done_read 5 cycles after each start -> grants 0001,0010,0100,1000,0001.
- RD_ACTIVE owner lane 2, rd_line_req=4'b1011 -> read_new_line=0; rd_line_req=4'b0100 -> read_new_line=1.
- WR_ACTIVE, wr_beat_valid toggling 1,0,1 -> ready_from_core follows same cycle; reset asserted mid-burst -> next edge all outputs at reset values.
- Watchdog enabled, TIMEOUT_WIDTH=4, no done -> timeout_err=1 after 15 ACTIVE cycles, RELEASE, flag sticky; disabled build -> grant held 100+ cycles, timeout_err=0.

Source files
------------

// File: rtl/oflow_mem_buffer_arbiter.sv
// Arbiter for one MEM buffer wrapper: a strict-priority write requester plus NUM_REQ round-robin read lanes.
// Optional watchdog is compiled in with `define OFLOW_MEM_ARB_WATCHDOG_EN.
module oflow_mem_buffer_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_N,
  input  logic               wr_req,
  input  logic               wr_beat_valid,
  output logic               wr_grant,
  input  logic [NUM_REQ-1:0] rd_req,
  input  logic [NUM_REQ-1:0] rd_line_req,
  output logic [NUM_REQ-1:0] rd_grant,
  input  logic               done_read,
  input  logic               done_write,
  output logic               start_read,
  output logic               start_write,
  output logic               rnw_st,
  output logic               read_new_line,
  output logic               ready_from_core,
  output logic               busy,
  output logic               timeout_err
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] LANE0 = NUM_REQ'(1);

  typedef enum logic [2:0] {
    IDLE, WR_START, WR_ACTIVE, RD_START, RD_ACTIVE, RELEASE
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] owner_idx;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_vld;
  logic             wd_expire;

  // Round-robin search: lowest offset from rr_ptr wins, so scan offsets downward.
  always_comb begin
    int idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (|(rd_req & (LANE0 << idx))) begin
        pick_vld = 1'b1;
        pick_idx = PTR_W'(idx);
      end
    end
  end

  assign ready_from_core = (state == WR_ACTIVE) && wr_beat_valid;
  assign read_new_line   = (state == RD_ACTIVE) && |(rd_line_req & rd_grant);
  assign busy            = wr_grant || |rd_grant;

`ifdef OFLOW_MEM_ARB_WATCHDOG_EN
  localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};
  logic [TIMEOUT_WIDTH-1:0] wd_cnt;
  logic                     act_pending;

  // Expires on the ACTIVE cycle whose increment would bring the counter to all-ones.
  assign act_pending = ((state == WR_ACTIVE) && !done_write) ||
                       ((state == RD_ACTIVE) && !done_read);
  assign wd_expire   = act_pending && (wd_cnt == WD_LAST);

  always_ff @(posedge clk) begin
    if (reset_N) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if ((state == WR_START) || (state == RD_START)) wd_cnt <= '0;
      else if (act_pending) wd_cnt <= wd_cnt + 1'b1;
      if (wd_expire) timeout_err <= 1'b1;
    end
  end
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset_N) begin
      state       <= IDLE;
      wr_grant    <= 1'b0;
      rd_grant    <= '0;
      start_read  <= 1'b0;
      start_write <= 1'b0;
      rnw_st      <= 1'b1;
      rr_ptr      <= '0;
      owner_idx   <= '0;
    end else begin
      start_read  <= 1'b0;
      start_write <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_req) begin
            state       <= WR_START;
            wr_grant    <= 1'b1;
            start_write <= 1'b1;
            rnw_st      <= 1'b0;
          end else if (pick_vld) begin
            state      <= RD_START;
            rd_grant   <= LANE0 << pick_idx;
            owner_idx  <= pick_idx;
            start_read <= 1'b1;
            rnw_st     <= 1'b1;
          end
        end
        WR_START: state <= WR_ACTIVE;
        RD_START: state <= RD_ACTIVE;
        WR_ACTIVE: begin
          if (done_write || wd_expire) begin
            state    <= RELEASE;
            wr_grant <= 1'b0;
          end
        end
        RD_ACTIVE: begin
          if (done_read || wd_expire) begin
            state    <= RELEASE;
            rd_grant <= '0;
            rr_ptr   <= (owner_idx == PTR_W'(NUM_REQ - 1)) ? '0 : owner_idx + 1'b1;
          end
        end
        RELEASE: begin
          state  <= IDLE;
          rnw_st <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
